// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command bus: word field positions, action/type codes,
// the queued update-request record and helpers that assemble 32-bit command words.
package sprite_cmd_pkg;

    localparam int CMD_W     = 32;
    localparam int DATA_W    = 13;
    localparam int COMP_LSB  = 26;
    localparam int CHILD_LSB = 21;
    localparam int ACT_LSB   = 17;
    localparam int TYPE_LSB  = 14;
    localparam int BUF_BIT   = 13;

    localparam logic [3:0] ACT_UPDATE = 4'b0001;
    localparam logic [3:0] ACT_COMMIT = 4'b1111;

    localparam logic [2:0] TYPE_NONE    = 3'b000;
    localparam logic [2:0] TYPE_VISFLIP = 3'b001;
    localparam logic [2:0] TYPE_X       = 3'b010;
    localparam logic [2:0] TYPE_Y       = 3'b011;
    localparam logic [2:0] TYPE_ATTR    = 3'b100;

    typedef struct packed {
        logic [5:0] comp;
        logic [4:0] child;
        logic [3:0] mask;
        logic       visible;
        logic       flip;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] attr;
    } upd_req_t;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [5:0]        comp,
        input logic [4:0]        child,
        input logic [3:0]        action,
        input logic [2:0]        cmd_type,
        input logic              buf_sel,
        input logic [DATA_W-1:0] data
    );
        logic [CMD_W-1:0] word;
        word                    = '0;
        word[COMP_LSB +: 6]     = comp;
        word[CHILD_LSB +: 5]    = child;
        word[ACT_LSB +: 4]      = action;
        word[TYPE_LSB +: 3]     = cmd_type;
        word[BUF_BIT]           = buf_sel;
        word[0 +: DATA_W]       = data;
        return word;
    endfunction

    // Index of the lowest set mask bit; words go out in mask-bit order 0..3.
    function automatic logic [1:0] first_field(input logic [3:0] mask);
        if (mask[0])      return 2'd0;
        else if (mask[1]) return 2'd1;
        else if (mask[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    function automatic logic [CMD_W-1:0] encode_update(
        input upd_req_t   req,
        input logic [1:0] field,
        input logic       buf_sel
    );
        case (field)
            2'd0:    return pack_cmd(req.comp, req.child, ACT_UPDATE, TYPE_VISFLIP, buf_sel,
                                     {req.visible, req.flip, 11'b0});
            2'd1:    return pack_cmd(req.comp, req.child, ACT_UPDATE, TYPE_X, buf_sel, {3'b0, req.x});
            2'd2:    return pack_cmd(req.comp, req.child, ACT_UPDATE, TYPE_Y, buf_sel, {3'b0, req.y});
            default: return pack_cmd(req.comp, req.child, ACT_UPDATE, TYPE_ATTR, buf_sel, {3'b0, req.attr});
        endcase
    endfunction

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Synchronous FIFO of sprite update requests with full/empty flags.
// The head entry is read combinationally so the encoder can launch a word on the pop cycle.
module sprite_cmd_fifo
    import sprite_cmd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  upd_req_t push_data,
    input  logic     pop,
    output upd_req_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    upd_req_t        mem [DEPTH];
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_cmd_encoder.sv
// Sprite command bus transmitter: queues sprite updates, serialises them into back-buffer
// update words and emits the buffer-toggle command on frame commit.
module sprite_cmd_encoder
    import sprite_cmd_pkg::*;
#(
    parameter int   FIFO_DEPTH = 8,
    parameter logic INIT_FRONT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [5:0]  upd_comp,
    input  logic [4:0]  upd_child,
    input  logic [3:0]  upd_mask,
    input  logic        upd_visible,
    input  logic        upd_flip,
    input  logic [9:0]  upd_x,
    input  logic [9:0]  upd_y,
    input  logic [9:0]  upd_attr,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [5:0]  commit_comp,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_data,
    output logic        front_buf,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    upd_req_t         entry_reg, entry_next;
    logic [CMD_W-1:0] cmd_data_reg, cmd_data_next;
    logic             cmd_valid_reg, cmd_valid_next;
    logic             front_reg, front_next;

    upd_req_t         fifo_head;
    upd_req_t         fifo_in;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             take_head;
    logic             xfer;

    assign fifo_in = '{comp: upd_comp, child: upd_child, mask: upd_mask,
                       visible: upd_visible, flip: upd_flip,
                       x: upd_x, y: upd_y, attr: upd_attr};

    assign upd_ready    = !fifo_full;
    assign fifo_push    = upd_valid && !fifo_full;
    assign commit_ready = (state_reg == ST_IDLE) && fifo_empty;
    assign busy         = (state_reg != ST_IDLE) || !fifo_empty;
    assign xfer         = cmd_valid_reg && cmd_ready;

    assign cmd_valid = cmd_valid_reg;
    assign cmd_data  = cmd_data_reg;
    assign front_buf = front_reg;

    sprite_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // entry_reg.mask holds only the fields still to be sent after the word on the bus.
    always_comb begin
        state_next     = state_reg;
        entry_next     = entry_reg;
        cmd_data_next  = cmd_data_reg;
        cmd_valid_next = cmd_valid_reg;
        front_next     = front_reg;
        take_head      = 1'b0;
        fifo_pop       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (commit_valid && commit_ready) begin
                    cmd_data_next  = pack_cmd(commit_comp, 5'd0, ACT_COMMIT, TYPE_NONE,
                                              ~front_reg, '0);
                    cmd_valid_next = 1'b1;
                    state_next     = ST_COMMIT;
                end else if (!fifo_empty) begin
                    take_head = 1'b1;
                end
            end
            ST_EMIT: begin
                if (xfer) begin
                    if (entry_reg.mask != 4'd0) begin
                        cmd_data_next   = encode_update(entry_reg, first_field(entry_reg.mask),
                                                        ~front_reg);
                        entry_next.mask = entry_reg.mask & (entry_reg.mask - 4'd1);
                    end else if (!fifo_empty) begin
                        take_head = 1'b1;
                    end else begin
                        cmd_valid_next = 1'b0;
                        state_next     = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                if (xfer) begin
                    front_next     = ~front_reg;
                    cmd_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                cmd_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase

        // An empty-mask entry is simply dropped; the pop cycle is its only cost.
        if (take_head) begin
            fifo_pop   = 1'b1;
            entry_next = fifo_head;
            if (fifo_head.mask != 4'd0) begin
                cmd_data_next   = encode_update(fifo_head, first_field(fifo_head.mask), ~front_reg);
                cmd_valid_next  = 1'b1;
                entry_next.mask = fifo_head.mask & (fifo_head.mask - 4'd1);
                state_next      = ST_EMIT;
            end else begin
                cmd_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            entry_reg     <= '0;
            cmd_data_reg  <= '0;
            cmd_valid_reg <= 1'b0;
            front_reg     <= INIT_FRONT;
        end else begin
            state_reg     <= state_next;
            entry_reg     <= entry_next;
            cmd_data_reg  <= cmd_data_next;
            cmd_valid_reg <= cmd_valid_next;
            front_reg     <= front_next;
        end
    end

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Scoreboard bench for sprite_cmd_encoder: expected words are queued at input accept and
// compared in order as the encoder hands them over.
module tb_sprite_cmd_encoder;

    localparam int   DEPTH  = 8;
    localparam logic INIT_F = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [5:0]  upd_comp;
    logic [4:0]  upd_child;
    logic [3:0]  upd_mask;
    logic        upd_visible;
    logic        upd_flip;
    logic [9:0]  upd_x;
    logic [9:0]  upd_y;
    logic [9:0]  upd_attr;
    logic        commit_valid;
    logic        commit_ready;
    logic [5:0]  commit_comp;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        front_buf;
    logic        busy;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] sb[$];
    logic        model_front;
    logic [31:0] held;

    always #5 clk = ~clk;

    sprite_cmd_encoder #(
        .FIFO_DEPTH (DEPTH),
        .INIT_FRONT (INIT_F)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_comp     (upd_comp),
        .upd_child    (upd_child),
        .upd_mask     (upd_mask),
        .upd_visible  (upd_visible),
        .upd_flip     (upd_flip),
        .upd_x        (upd_x),
        .upd_y        (upd_y),
        .upd_attr     (upd_attr),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_comp  (commit_comp),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .front_buf    (front_buf),
        .busy         (busy)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_word(input logic [5:0] comp, input logic [4:0] child,
                                            input logic [3:0] act, input logic [2:0] typ,
                                            input logic b, input logic [12:0] data);
        return {comp, child, act, typ, b, data};
    endfunction

    task automatic model_update(input logic b);
        if (upd_mask[0]) sb.push_back(mk_word(upd_comp, upd_child, 4'b0001, 3'b001, b, {upd_visible, upd_flip, 11'b0}));
        if (upd_mask[1]) sb.push_back(mk_word(upd_comp, upd_child, 4'b0001, 3'b010, b, {3'b0, upd_x}));
        if (upd_mask[2]) sb.push_back(mk_word(upd_comp, upd_child, 4'b0001, 3'b011, b, {3'b0, upd_y}));
        if (upd_mask[3]) sb.push_back(mk_word(upd_comp, upd_child, 4'b0001, 3'b100, b, {3'b0, upd_attr}));
    endtask

    // Runs at the falling edge: whatever is valid/ready now transfers on the next rising edge.
    task automatic monitor_loop();
        logic [31:0] exp_word;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                model_front = INIT_F;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    check_value("word_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp_word = sb.pop_front();
                        check_value("cmd_word", cmd_data, exp_word);
                        $display("[TB] word 0x%08h expected 0x%08h", cmd_data, exp_word);
                    end
                end
                if (commit_valid && commit_ready) begin
                    sb.push_back(mk_word(commit_comp, 5'd0, 4'b1111, 3'b000, ~model_front, 13'd0));
                    model_front = ~model_front;
                end
                if (upd_valid && upd_ready) begin
                    model_update(~model_front);
                end
            end
        end
    endtask

    task automatic send_upd(input logic [5:0] comp, input logic [4:0] child, input logic [3:0] mask,
                            input logic vis, input logic flip,
                            input logic [9:0] x, input logic [9:0] y, input logic [9:0] attr);
        int waited = 0;
        upd_valid = 1'b1; upd_comp = comp; upd_child = child; upd_mask = mask;
        upd_visible = vis; upd_flip = flip; upd_x = x; upd_y = y; upd_attr = attr;
        @(negedge clk);
        while (!upd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_value("upd_accept", 32'(upd_ready), 32'd1);
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic send_commit(input logic [5:0] comp);
        int waited = 0;
        commit_valid = 1'b1; commit_comp = comp;
        @(negedge clk);
        while (!commit_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_value("commit_accept", 32'(commit_ready), 32'd1);
        @(posedge clk); #1;
        commit_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int waited = 0;
        @(negedge clk);
        while ((busy || cmd_valid || sb.size() != 0) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check_value({tag, "_idle"}, 32'({busy, cmd_valid}), 32'd0);
        check_value({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_stimulus();
        reset = 1'b1; upd_valid = 1'b0; commit_valid = 1'b0; commit_comp = '0; cmd_ready = 1'b1;
        upd_comp = '0; upd_child = '0; upd_mask = '0; upd_visible = 1'b0; upd_flip = 1'b0;
        upd_x = '0; upd_y = '0; upd_attr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_value("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_value("rst_cmd_data", cmd_data, 32'd0);
        check_value("rst_upd_ready", 32'(upd_ready), 32'd1);
        check_value("rst_commit_ready", 32'(commit_ready), 32'd1);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_front", 32'(front_buf), 32'(INIT_F));
        @(posedge clk); #1;

        // Full four-word entry: valid one cycle after accept, then back-to-back words.
        send_upd(6'b001000, 5'd0, 4'hF, 1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
        check_value("lat_edge_k", 32'(cmd_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_value("stream_valid", 32'(cmd_valid), 32'd1);
        end
        @(posedge clk); #1;
        check_value("stream_end", 32'(cmd_valid), 32'd0);
        wait_drain("first");

        send_commit(6'b001000);
        wait_drain("commit1");
        check_value("front_after_commit", 32'(front_buf), 32'd1);

        send_upd(6'd8, 5'd2, 4'hF, 1'b0, 1'b1, 10'd1, 10'd2, 10'd3);
        wait_drain("post_commit");
        send_upd(6'd5, 5'd3, 4'b0100, 1'b1, 1'b1, 10'd9, 10'd7, 10'd9);
        wait_drain("y_only");
        send_upd(6'd6, 5'd1, 4'b0000, 1'b1, 1'b1, 10'd9, 10'd9, 10'd9);
        wait_drain("mask_zero");

        // Stall mid-entry: the second word must stay on the bus unchanged.
        cmd_ready = 1'b0;
        send_upd(6'd12, 5'd4, 4'hF, 1'b1, 1'b1, 10'd300, 10'd400, 10'd500);
        @(posedge clk); #1;
        check_value("stall_first_valid", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        held = cmd_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_value("stall_data", cmd_data, held);
            check_value("stall_valid", 32'(cmd_valid), 32'd1);
        end
        cmd_ready = 1'b1;
        wait_drain("stall");

        // Fill the queue while stalled; one entry sits in the encoder, DEPTH in the FIFO.
        cmd_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            send_upd(6'(i + 20), 5'(i), 4'(i + 1), 1'(i), 1'(i + 1), 10'(i * 7), 10'(i * 11), 10'(i * 13));
        end
        check_value("full_upd_ready", 32'(upd_ready), 32'd0);
        check_value("full_busy", 32'(busy), 32'd1);
        check_value("full_commit_ready", 32'(commit_ready), 32'd0);
        upd_valid = 1'b1; upd_comp = 6'd63; upd_mask = 4'hF;
        repeat (3) @(posedge clk);
        #1 upd_valid = 1'b0;
        cmd_ready = 1'b1;
        wait_drain("fill");

        // Commit and update accepted together: commit goes first, update targets new back buffer.
        commit_valid = 1'b1; commit_comp = 6'd2;
        upd_valid = 1'b1; upd_comp = 6'd3; upd_child = 5'd7; upd_mask = 4'b0110;
        upd_x = 10'd33; upd_y = 10'd44;
        @(negedge clk);
        check_value("simul_commit_ready", 32'(commit_ready), 32'd1);
        check_value("simul_upd_ready", 32'(upd_ready), 32'd1);
        @(posedge clk); #1;
        commit_valid = 1'b0; upd_valid = 1'b0;
        wait_drain("simul");
        check_value("front_after_simul", 32'(front_buf), 32'd0);

        // Update queued while the commit word is stalled.
        cmd_ready = 1'b0;
        send_commit(6'd9);
        send_upd(6'd10, 5'd1, 4'b1001, 1'b0, 1'b1, 10'd5, 10'd6, 10'd777);
        check_value("commit_hold_busy", 32'(busy), 32'd1);
        cmd_ready = 1'b1;
        wait_drain("queued_in_commit");
        check_value("front_after_third", 32'(front_buf), 32'd1);

        // Reset while stalled mid-entry.
        cmd_ready = 1'b0;
        send_upd(6'd14, 5'd2, 4'hF, 1'b1, 1'b0, 10'd1, 10'd2, 10'd3);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_value("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_value("mid_rst_cmd_data", cmd_data, 32'd0);
        check_value("mid_rst_busy", 32'(busy), 32'd0);
        check_value("mid_rst_front", 32'(front_buf), 32'(INIT_F));
        check_value("mid_rst_upd_ready", 32'(upd_ready), 32'd1);
        check_value("mid_rst_commit_ready", 32'(commit_ready), 32'd1);
        reset = 1'b0;
        cmd_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        wait_drain("after_reset");
    endtask

    initial begin
        model_front = INIT_F;
        fork
            monitor_loop();
            run_stimulus();
        join_any
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
